prog_loader: RTL

//  UART-to-memory loader for the program/data memory (B-bit words, W address bits).

---
 rtl/prog_loader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : UART-to-memory loader. Consumes a byte stream of
//             [len_hi, len_lo, N words MSB-first, optional checksum] and
//             issues one single-cycle memory write per word at consecutive
//             addresses starting at 0.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    B        word width in bits (multiple of 8)
//    W        memory address width (capacity 2**W words, W <= 16)
//    TIMEOUT  max clk cycles between rx bytes while busy
//  Ports
//    clk           system clock, rising edge
//    reset         asynchronous, active-low reset
//    load_start    one-cycle pulse, arms the loader when idle
//    rx_done_tick  one-cycle pulse, rx_data holds a new byte
//    rx_data       received byte
//    wr_en         memory write strobe, one cycle per word
//    w_addr        memory write address
//    w_data        memory write data
//    busy          high while a load is in progress
//    load_done     one-cycle completion pulse
//    load_err      sticky error flag, cleared by the next accepted start
//    words_loaded  words written in the current/last load
//  Configuration
//    PROG_LOADER_CHECKSUM_EN  adds a trailing XOR checksum byte check
// ============================================================================
module prog_loader #(
  parameter int B       = 16,
  parameter int W       = 11,
  parameter int TIMEOUT = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_start,
  input  logic         rx_done_tick,
  input  logic [7:0]   rx_data,
  output logic         wr_en,
  output logic [W-1:0] w_addr,
  output logic [B-1:0] w_data,
  output logic         busy,
  output logic         load_done,
  output logic         load_err,
  output logic [W:0]   words_loaded
);

  localparam int          NB  = B / 8;
  localparam int          BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int          TW  = $clog2(TIMEOUT + 1);
  localparam logic [31:0] CAP = 32'(2 ** W);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA
`ifdef PROG_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  state_t         state;
  logic [7:0]     len_hi;
  logic [15:0]    len;
  logic [B-1:0]   word;
  logic [BCW-1:0] byte_cnt;
  logic [TW-1:0]  tmo_cnt;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]     chk;
`endif

  logic [15:0]    hdr_len;
  logic [B-1:0]   word_next;
  logic [W:0]     count_next;
  logic           last_byte;
  logic           last_word;
  logic           tmo_hit;

  assign hdr_len    = {len_hi, rx_data};
  assign word_next  = (word << 8) | B'(rx_data);
  assign count_next = words_loaded + (W+1)'(1);
  assign last_byte  = (byte_cnt == BCW'(NB - 1));
  assign last_word  = (32'(count_next) == 32'(len));
  // TIMEOUT consecutive cycles without a byte
  assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      len_hi       <= '0;
      len          <= '0;
      word         <= '0;
      byte_cnt     <= '0;
      tmo_cnt      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk          <= '0;
`endif
      wr_en        <= 1'b0;
      w_addr       <= '0;
      w_data       <= '0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      if (state == IDLE) begin
        // Any rx byte in the same cycle as the start is intentionally dropped
        if (load_start) begin
          state        <= LEN_HI;
          busy         <= 1'b1;
          load_err     <= 1'b0;
          words_loaded <= '0;
          byte_cnt     <= '0;
          tmo_cnt      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          chk          <= '0;
`endif
        end
      end else if (rx_done_tick) begin
        tmo_cnt <= '0;
        case (state)
          LEN_HI: begin
            len_hi <= rx_data;
            state  <= LEN_LO;
          end
          LEN_LO: begin
            if (hdr_len == 16'd0) begin
              load_done <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else if ({16'd0, hdr_len} > CAP) begin
              // Rejecting here guarantees the address never wraps
              load_err <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              len   <= hdr_len;
              state <= DATA;
            end
          end
          DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
            chk <= chk ^ rx_data;
`endif
            word <= word_next;
            if (last_byte) begin
              byte_cnt     <= '0;
              wr_en        <= 1'b1;
              w_data       <= word_next;
              w_addr       <= words_loaded[W-1:0];
              words_loaded <= count_next;
              if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                load_done <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
`endif
              end
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          CHK: begin
            if (rx_data == chk) load_done <= 1'b1;
            else                load_err  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
`endif
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end else if (tmo_hit) begin
        load_err <= 1'b1;
        busy     <= 1'b0;
        tmo_cnt  <= '0;
        state    <= IDLE;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

endmodule
`default_nettype wire
